// File: rtl/move_apply_unit.sv
// Pipelined board-update engine: applies one move to one board per accepted request and
// queues the successor board, tag and capture report in an output FIFO.
`ifndef NB_PIECES
`define NB_PIECES 5
`endif

package move_apply_pkg;
    localparam int NB_PIECES = `NB_PIECES;
    // Piece class indices; kings are tracked as coordinates, not bitboards.
    localparam int KNIGHT_IDX = 0;
    localparam int BISHOP_IDX = 1;
    localparam int ROOK_IDX   = 2;
    localparam int QUEEN_IDX  = 3;
    localparam int PAWN_IDX   = 4;

    localparam logic [2:0] SPECIAL_UNKNOWN        = 3'd0;
    localparam logic [2:0] SPECIAL_NONE           = 3'd1;
    localparam logic [2:0] SPECIAL_CASTLE         = 3'd2;
    localparam logic [2:0] SPECIAL_EN_PASSANT     = 3'd3;
    localparam logic [2:0] SPECIAL_PROMOTE_KNIGHT = 3'd4;
    localparam logic [2:0] SPECIAL_PROMOTE_BISHOP = 3'd5;
    localparam logic [2:0] SPECIAL_PROMOTE_ROOK   = 3'd6;
    localparam logic [2:0] SPECIAL_PROMOTE_QUEEN  = 3'd7;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        logic [2:0] special;
    } move_t;

    // castle[colour][side]: side 0 = king side (file 7), side 1 = queen side (file 0)
    typedef struct packed {
        logic [NB_PIECES-1:0][63:0] pieces;
        logic [63:0]                pieces_w;
        logic [1:0][5:0]            kings;
        logic [1:0][1:0]            castle;
        logic [1:0]                 checkmate;
        logic [3:0]                 en_passant;
        logic [6:0]                 ply50;
        logic [9:0]                 ply;
    } board_t;
endpackage

module move_apply_unit
    import move_apply_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_IN     = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  move_t                         move_in,
    input  board_t                        board_in,
    input  logic [TAG_W-1:0]              tag_in,
    input  logic                          flush_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output board_t                        board_out,
    output logic [TAG_W-1:0]              tag_out,
    output logic                          captured_out,
    output logic [`NB_PIECES-1:0]         captured_piece_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        board_t                board;
        logic [TAG_W-1:0]      tag;
        logic                  captured;
        logic [NB_PIECES-1:0]  captured_piece;
    } entry_t;

    function automatic entry_t apply_move(input board_t b, input move_t m);
        entry_t r;
        board_t n;
        logic is_b, pawn, captured, far, corner, ep_en;
        logic [NB_PIECES-1:0] is_piece, cap, ep_cap;
        logic [63:0] src_bit, dst_bit, rook_src_bit, rook_dst_bit;
        logic [1:0] king_cap;
        logic [5:0] ep_sq;
        n       = b;
        is_b    = b.ply[0];
        src_bit = 64'd1 << m.src;
        dst_bit = 64'd1 << m.dst;
        for (int i = 0; i < NB_PIECES; i++) begin
            is_piece[i]  = b.pieces[i][m.src];
            cap[i]       = b.pieces[i][m.dst];
            n.pieces[i]  = b.pieces[i] & ~(src_bit | dst_bit);
        end
        pawn       = is_piece[PAWN_IDX];
        n.pieces_w = b.pieces_w & ~src_bit;
        n.pieces_w = is_b ? (n.pieces_w & ~dst_bit) : (n.pieces_w | dst_bit);
        king_cap    = {m.dst == b.kings[1], m.dst == b.kings[0]};
        n.checkmate = b.checkmate | king_cap;
        captured    = (|cap) || (|king_cap);
        far = (m.src[2:0] > m.dst[2:0]) ? (m.src[2:0] - m.dst[2:0] > 3'd1)
                                        : (m.dst[2:0] - m.src[2:0] > 3'd1);
        rook_src_bit = 64'd1 << {m.src[5:3], (m.dst < m.src) ? 3'd0 : 3'd7};
        rook_dst_bit = 64'd1 << {m.src[5:3], (m.dst < m.src) ? 3'd3 : 3'd5};
        if (m.src == b.kings[0] || m.src == b.kings[1]) begin
            n.kings[is_b]  = m.dst;
            n.castle[is_b] = 2'b00;
            if (m.special == SPECIAL_CASTLE || (m.special == SPECIAL_UNKNOWN && far)) begin
                n.pieces[ROOK_IDX] = (n.pieces[ROOK_IDX] & ~rook_src_bit) | rook_dst_bit;
                n.pieces_w = n.pieces_w & ~rook_src_bit;
                if (!is_b) n.pieces_w = n.pieces_w | rook_dst_bit;
            end
        end
        corner = (m.src[5:3] == (is_b ? 3'd7 : 3'd0)) && (m.src[2:0] == 3'd0 || m.src[2:0] == 3'd7);
        if (is_piece[ROOK_IDX] && corner) n.castle[is_b][m.src[2:0] == 3'd0] = 1'b0;
        n.en_passant = {pawn && ((m.dst > m.src) ? (m.dst - m.src == 6'd16) : (m.src - m.dst == 6'd16)),
                        m.dst[2:0]};
        case (m.special)
            SPECIAL_PROMOTE_KNIGHT: is_piece = NB_PIECES'(1) << KNIGHT_IDX;
            SPECIAL_PROMOTE_BISHOP: is_piece = NB_PIECES'(1) << BISHOP_IDX;
            SPECIAL_PROMOTE_ROOK:   is_piece = NB_PIECES'(1) << ROOK_IDX;
            SPECIAL_PROMOTE_QUEEN:  is_piece = NB_PIECES'(1) << QUEEN_IDX;
            default: ;
        endcase
        // The captured pawn sits behind the destination, on the mover's side of it.
        ep_en  = (m.special == SPECIAL_EN_PASSANT) ||
                 (m.special == SPECIAL_UNKNOWN && pawn && m.src[2:0] != m.dst[2:0] && !captured);
        ep_sq  = is_b ? m.dst + 6'd8 : m.dst - 6'd8;
        ep_cap = '0;
        if (ep_en) begin
            for (int i = 0; i < NB_PIECES; i++) begin
                ep_cap[i]          = n.pieces[i][ep_sq];
                n.pieces[i][ep_sq] = 1'b0;
            end
            cap      = cap | ep_cap;
            captured = captured || (|ep_cap);
        end
        for (int i = 0; i < NB_PIECES; i++) begin
            if (is_piece[i]) n.pieces[i] = n.pieces[i] | dst_bit;
        end
        n.ply50 = (captured || pawn) ? 7'd0 : b.ply50 + 7'd1;
        n.ply   = b.ply + 10'd1;
        r.board          = n;
        r.tag            = '0;
        r.captured       = captured;
        r.captured_piece = cap;
        return r;
    endfunction

    // Handshake: a request transfers on a rising edge where valid_in && ready_out (and no flush);
    // a result transfers where valid_out && ready_in. ready_out never looks at valid_in or ready_in.
    logic             accept, push, pop;
    logic             stage_valid;
    move_t            stage_move;
    board_t           stage_board;
    logic [TAG_W-1:0] stage_tag;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    entry_t           wr_entry, head;
    entry_t           mem [FIFO_DEPTH];

    assign ready_out = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign accept    = valid_in && ready_out && !flush_in;

    generate
        if (REG_IN != 0) begin : g_reg
            always_ff @(posedge clk_in) begin
                if (rst_in || flush_in) stage_valid <= 1'b0;
                else                    stage_valid <= accept;
                if (accept) begin
                    stage_move  <= move_in;
                    stage_board <= board_in;
                    stage_tag   <= tag_in;
                end
            end
            assign inflight = CW'(stage_valid);
        end else begin : g_comb
            assign stage_valid = accept;
            assign stage_move  = move_in;
            assign stage_board = board_in;
            assign stage_tag   = tag_in;
            assign inflight    = '0;
        end
    endgenerate

    always_comb begin
        wr_entry     = apply_move(stage_board, stage_move);
        wr_entry.tag = stage_tag;
    end

    assign valid_out = (count != '0);
    assign pop       = valid_out && ready_in && !flush_in;
    assign push      = stage_valid && !flush_in && ((count < CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rst_in) mem[wr_ptr] <= wr_entry;
    end

    // Head fields read as zero whenever the FIFO is empty, so reset needs no storage clear.
    assign head               = valid_out ? mem[rd_ptr] : '0;
    assign board_out          = head.board;
    assign tag_out            = head.tag;
    assign captured_out       = head.captured;
    assign captured_piece_out = head.captured_piece;
    assign count_out          = count;
endmodule
